// File: rtl/device_mixer_pkg.sv
// Shared types and helpers for device_mixer: FSM states, gain shift,
// accumulator sizing and signed saturation.
package device_mixer_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, SAT, FILT} mix_state_t;

  // vol/8 gain: 8 is unity.
  localparam int GAIN_SHIFT = 3;

  function automatic int acc_width(input int sample_w, input int vol_w, input int channels);
    return sample_w + vol_w + $clog2(channels) + 1;
  endfunction

  // Clamp val to the signed range of out_w bits; clipped reports whether it did.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] val,
                                                  input int out_w,
                                                  output logic clipped);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    clipped = 1'b0;
    if (val > hi) begin
      clipped = 1'b1;
      return hi;
    end
    if (val < lo) begin
      clipped = 1'b1;
      return lo;
    end
    return val;
  endfunction

endpackage

// File: rtl/device_mixer_dc_block.sv
// One-pole DC-blocking high-pass: y = x - x_prev + y_prev - (y_prev >>> 8).
// Used by device_mixer only when DEVICE_MIXER_DC_BLOCK_EN is defined.
module mixer_dc_block
  import device_mixer_pkg::*;
#(
  parameter int SAMPLE_W = 16
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic signed [SAMPLE_W-1:0] x,
  output logic signed [SAMPLE_W-1:0] y,
  output logic                       clipped
);

  localparam int INT_W = SAMPLE_W + 2;

  logic signed [SAMPLE_W-1:0] x_prev_q, x_prev_d;
  logic signed [INT_W-1:0]    y_prev_q, y_prev_d;
  logic signed [INT_W-1:0]    y_int;
  logic                       int_clip, out_clip;

  always_comb begin
    y_int = INT_W'(saturate(64'(x) - 64'(x_prev_q) + 64'(y_prev_q) - 64'(y_prev_q >>> 8),
                            INT_W, int_clip));
    y       = SAMPLE_W'(saturate(64'(y_int), SAMPLE_W, out_clip));
    clipped = int_clip | out_clip;
    x_prev_d = in_valid ? x     : x_prev_q;
    y_prev_d = in_valid ? y_int : y_prev_q;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      x_prev_q <= '0;
      y_prev_q <= '0;
    end else begin
      x_prev_q <= x_prev_d;
      y_prev_q <= y_prev_d;
    end
  end

endmodule

// File: rtl/device_mixer.sv
// Combines CHANNELS device outputs: sequential gain/MAC audio mixer with
// saturation, plus AND-merged CPU read bus with collision flag.
// Optional DC-blocking filter after saturation: DEVICE_MIXER_DC_BLOCK_EN.
module device_mixer
  import device_mixer_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SAMPLE_W = 16,
  parameter int VOL_W    = 4
) (
  input  logic                               clk_sys,
  input  logic                               reset,
  input  logic                               sample_tick,
  input  logic [CHANNELS-1:0][SAMPLE_W-1:0]  ch_sound,
  input  logic [CHANNELS-1:0][VOL_W-1:0]     ch_volume,
  input  logic [CHANNELS-1:0]                ch_enable,
  input  logic [CHANNELS-1:0][7:0]           dev_data,
  input  logic [CHANNELS-1:0]                dev_output_rq,
  output logic signed [SAMPLE_W-1:0]         sound,
  output logic                               sound_valid,
  output logic                               clip,
  output logic                               overrun,
  output logic [7:0]                         data,
  output logic                               output_rq,
  output logic                               collision
);

  localparam int ACC_W  = acc_width(SAMPLE_W, VOL_W, CHANNELS);
  localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PROD_W = SAMPLE_W + VOL_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

  mix_state_t                        state_q, state_d;
  logic signed [ACC_W-1:0]           acc_q, acc_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic [CHANNELS-1:0][SAMPLE_W-1:0] snap_sound_q, snap_sound_d;
  logic [CHANNELS-1:0][VOL_W-1:0]    snap_volume_q, snap_volume_d;
  logic [CHANNELS-1:0]               snap_enable_q, snap_enable_d;
  logic signed [SAMPLE_W-1:0]        sound_q, sound_d;
  logic                              sound_valid_q, sound_valid_d;
  logic                              clip_q, clip_d;
  logic                              overrun_q, overrun_d;
  logic                              collision_q, collision_d;
  logic signed [PROD_W-1:0]          prod;
  logic signed [SAMPLE_W-1:0]        sat_res;
  logic                              sat_clip;

`ifdef DEVICE_MIXER_DC_BLOCK_EN
  logic signed [SAMPLE_W-1:0] filt_in_q, filt_in_d;
  logic signed [SAMPLE_W-1:0] dc_y;
  logic                       dc_clip;

  mixer_dc_block #(.SAMPLE_W(SAMPLE_W)) u_dc_block (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .in_valid (state_q == FILT),
    .x        (filt_in_q),
    .y        (dc_y),
    .clipped  (dc_clip)
  );
`endif

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    idx_d         = idx_q;
    snap_sound_d  = snap_sound_q;
    snap_volume_d = snap_volume_q;
    snap_enable_d = snap_enable_q;
    sound_d       = sound_q;
    sound_valid_d = 1'b0;
    clip_d        = clip_q;
    overrun_d     = sample_tick && (state_q != IDLE);
    prod          = $signed(snap_sound_q[idx_q]) * $signed({1'b0, snap_volume_q[idx_q]});
    sat_res       = SAMPLE_W'(saturate(64'(acc_q >>> GAIN_SHIFT), SAMPLE_W, sat_clip));
`ifdef DEVICE_MIXER_DC_BLOCK_EN
    filt_in_d     = filt_in_q;
`endif

    case (state_q)
      IDLE: begin
        if (sample_tick) begin
          snap_sound_d  = ch_sound;
          snap_volume_d = ch_volume;
          snap_enable_d = ch_enable;
          acc_d         = '0;
          idx_d         = '0;
          state_d       = ACCUM;
        end
      end
      ACCUM: begin
        if (snap_enable_q[idx_q]) acc_d = acc_q + ACC_W'(prod);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = SAT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      SAT: begin
        clip_d = clip_q | sat_clip;
`ifdef DEVICE_MIXER_DC_BLOCK_EN
        filt_in_d = sat_res;
        state_d   = FILT;
`else
        sound_d       = sat_res;
        sound_valid_d = 1'b1;
        state_d       = IDLE;
`endif
      end
`ifdef DEVICE_MIXER_DC_BLOCK_EN
      FILT: begin
        sound_d       = dc_y;
        sound_valid_d = 1'b1;
        clip_d        = clip_q | dc_clip;
        state_d       = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Read bus: open-drain style AND of all active drivers; idle bus reads FF.
  always_comb begin
    data = 8'hFF;
    for (int i = 0; i < CHANNELS; i++) begin
      if (dev_output_rq[i]) data &= dev_data[i];
    end
    output_rq   = |dev_output_rq;
    collision_d = $countones(dev_output_rq) > 1;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      idx_q         <= '0;
      // NOTE: the snapshot is plain flops, not RAM, so it is reset along with the rest.
      snap_sound_q  <= '0;
      snap_volume_q <= '0;
      snap_enable_q <= '0;
      sound_q       <= '0;
      sound_valid_q <= 1'b0;
      clip_q        <= 1'b0;
      overrun_q     <= 1'b0;
      collision_q   <= 1'b0;
`ifdef DEVICE_MIXER_DC_BLOCK_EN
      filt_in_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      idx_q         <= idx_d;
      snap_sound_q  <= snap_sound_d;
      snap_volume_q <= snap_volume_d;
      snap_enable_q <= snap_enable_d;
      sound_q       <= sound_d;
      sound_valid_q <= sound_valid_d;
      clip_q        <= clip_d;
      overrun_q     <= overrun_d;
      collision_q   <= collision_d;
`ifdef DEVICE_MIXER_DC_BLOCK_EN
      filt_in_q     <= filt_in_d;
`endif
    end
  end

  assign sound       = sound_q;
  assign sound_valid = sound_valid_q;
  assign clip        = clip_q;
  assign overrun     = overrun_q;
  assign collision   = collision_q;

endmodule

// File: doc/device_mixer.md
Name: device_mixer

Overview:
- Parametrised successor to the fixed slot-device combiner.
- Merges CHANNELS device outputs into one audio stream and one CPU read path.
- Audio path: per-channel gain, a sequential multiply-accumulate over channels, saturation, and a registered sample strobe.
- CPU path: read-data merge gated by each device's output request, plus multi-driver collision detection.
- Sits between the device instances and the slot/audio output logic.

Parameters:
- CHANNELS, 4: number of device inputs; range 1..16.
- SAMPLE_W, 16: signed sample width of inputs and output.
- VOL_W, 4: unsigned per-channel gain width. Gain = vol/8, so 8 is unity and 15 is 1.875x.

Ports:
- clk_sys  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- sample_tick  input  1  one-cycle strobe; start mixing one sample.
- ch_sound  input  CHANNELS x SAMPLE_W signed  per-device audio.
- ch_volume  input  CHANNELS x VOL_W  per-device gain.
- ch_enable  input  CHANNELS  channel participates in the mix.
- dev_data  input  CHANNELS x 8  per-device read data.
- dev_output_rq  input  CHANNELS  device drives the read bus this cycle.
- sound  output  SAMPLE_W signed  mixed, saturated sample.
- sound_valid  output  1  one-cycle pulse when sound updates.
- clip  output  1  sticky; set when saturation occurred, cleared by reset only.
- overrun  output  1  one-cycle pulse; sample_tick arrived while busy.
- data  output  8  merged read data (combinational).
- output_rq  output  1  OR of dev_output_rq (combinational).
- collision  output  1  registered; high one cycle after any cycle with 2+ dev_output_rq.

Behaviour:
- Reset values: sound=0, sound_valid=0, clip=0, overrun=0, collision=0, FSM=IDLE, accumulator=0, channel index=0, snapshot=0.
- Accumulator width: ACC_W = SAMPLE_W + VOL_W + clog2(CHANNELS) + 1, signed.
- IDLE:
  - On sample_tick, snapshot ch_sound, ch_volume and ch_enable.
  - Clear the accumulator, set idx=0, go to ACCUM.
- ACCUM:
  - Each cycle: if snap_enable[idx], add snap_sound[idx] * snap_volume[idx] to the accumulator. The product is signed and the volume is zero-extended.
  - idx increments each cycle. When idx = CHANNELS-1, go to SAT.
  - ACCUM lasts exactly CHANNELS cycles.
- SAT:
  - Arithmetic-shift the accumulator right by 3; the shift truncates toward -inf.
  - Clamp to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1]. If clamped, set clip.
  - Register the result into sound, pulse sound_valid, return to IDLE.
- Latency: sound_valid asserts CHANNELS+2 cycles after the sample_tick cycle. The IDLE capture counts as one cycle.
- sample_tick in ACCUM or SAT: ignored; the snapshot is unchanged; overrun pulses on the next cycle.
- sample_tick in the same cycle as the SAT→IDLE transition counts as busy, so it is ignored and raises overrun.
- Input changes after the snapshot have no effect on the sample in flight.
- Read merge: data = bitwise AND of dev_data[i] over all i with dev_output_rq[i]=1. With no requester, data=8'hFF.
- collision: registered popcount(dev_output_rq) >= 2. It does not alter data; the AND merge still applies.
- Reset mid-operation: FSM goes to IDLE immediately; no sound_valid is produced for the aborted sample.

Optional Feature:
- Macro: DEVICE_MIXER_DC_BLOCK_EN.
- Defined:
  - A one-pole DC-blocking high-pass is inserted after SAT: y = x - x_prev + y_prev - (y_prev >>> 8).
  - The internal width is SAMPLE_W+2, and the output is saturated again to SAMPLE_W. This saturation also sets clip.
  - x_prev and y_prev reset to 0.
  - Adds one cycle of latency, giving CHANNELS+3 cycles.
- Undefined: no filter; latency is CHANNELS+2.

Decomposition:
- Package device_mixer_pkg holds:
  - the mix_state_t enum {IDLE, ACCUM, SAT, FILT};
  - the constant GAIN_SHIFT=3;
  - an acc_width(SAMPLE_W, VOL_W, CHANNELS) function;
  - a saturate function.
- Sub-module mixer_dc_block: the DC filter, instantiated only under DEVICE_MIXER_DC_BLOCK_EN.

Test Plan:
- CHANNELS=4, all vol=8, all enabled, ch_sound={100,200,-50,0}, pulse sample_tick → after exactly 6 cycles sound=250, sound_valid is a single-cycle pulse, clip=0.
- All ch_sound=16'h7000, vol=15, enabled → sound=16'h7FFF, clip=1 and stays 1 through later unclipped samples until reset.
- ch_enable=4'b0101, ch_sound={1000,1000,1000,1000}, vol=8 → sound=2000. Changing ch_sound during ACCUM leaves sound=2000.
- sample_tick, then a second sample_tick 2 cycles later → overrun pulses once, exactly one sound_valid, result from the first snapshot only.
- dev_output_rq=4'b0000 → data=FF, output_rq=0. rq=4'b0001 with data0=3C → data=3C, collision=0. rq=4'b0011, data0=F0, data1=3C → data=30, collision=1 on the next cycle.
- Assert reset during ACCUM → all outputs return to their reset values, no sound_valid follows. With DEVICE_MIXER_DC_BLOCK_EN, a constant 1000 input decays toward 0 over successive samples.
